data_mem_ctrl: RTL

Data-memory access controller between the MEM pipeline stage and the external word-wide data bus. Takes one load/store request per instruction (byte/half/word, signed or unsigned), checks alignment, runs a req/ack bus transaction with per-byte enables, and returns the extracted, extended load data. Holds the pipeline with `stall` while a transaction is outstanding and reports illegal or timed-out accesses on `access_err`.

---
 rtl/proc_pkg.sv | 28 ++
 rtl/mem_align.sv | 42 ++++
 rtl/data_mem_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the processor memory path: access-size encodings,
// the data-memory controller state type and the alignment legality rule.
package proc_pkg;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } dmem_state_t;

  // Byte accesses go anywhere, halves need an even address, words need a
  // word-aligned address; the reserved size is never legal.
  function automatic logic access_legal(input logic [1:0] len, input logic [1:0] off);
    logic ok;
    case (len)
      LEN_BYTE: ok = 1'b1;
      LEN_HALF: ok = ~off[0];
      LEN_WORD: ok = (off == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for the data bus: the store path moves right-aligned
// store data onto its lanes and builds byte enables, the load path pulls the
// addressed lane back down and sign- or zero-extends it.
module mem_align
  import proc_pkg::*;
(
  input  logic [1:0]  st_len,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  input  logic [1:0]  ld_len,
  input  logic [1:0]  ld_off,
  input  logic        ld_sign,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  // Store path: lane shift and byte enables from size and low address bits.
  always_comb begin
    st_lanes = st_data << {st_off, 3'b000};
    case (st_len)
      LEN_BYTE: st_be = 4'b0001 << st_off;
      LEN_HALF: st_be = 4'b0011 << st_off;
      LEN_WORD: st_be = 4'b1111;
      default:  st_be = '0;
    endcase
  end

  // Load path: shift the addressed lane to bit 0, truncate, then extend.
  always_comb begin
    ld_shifted = ld_word >> {ld_off, 3'b000};
    case (ld_len)
      LEN_BYTE: ld_data = {{24{ld_sign & ld_shifted[7]}}, ld_shifted[7:0]};
      LEN_HALF: ld_data = {{16{ld_sign & ld_shifted[15]}}, ld_shifted[15:0]};
      default:  ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: accepts one load/store from the MEM stage,
// runs a req/ack word-bus transaction with byte enables, returns extended
// load data and stalls the pipeline while the access is outstanding.
module data_mem_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [1:0]  length,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        access_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [3:0]       bus_be_q, bus_be_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [1:0]       len_q, len_d;
  logic             sign_q, sign_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             tmo_err_q, tmo_err_d;

  logic        one_en, any_en, req_ok, req_bad;
  logic [3:0]  st_be;
  logic [31:0] st_lanes, ld_data;

  mem_align u_align (
    .st_len   (length),
    .st_off   (addr[1:0]),
    .st_data  (write_data),
    .st_be    (st_be),
    .st_lanes (st_lanes),
    .ld_len   (len_q),
    .ld_off   (off_q),
    .ld_sign  (sign_q),
    .ld_word  (bus_rdata),
    .ld_data  (ld_data)
  );

  // Request classification in IDLE and the pipeline-facing outputs.
  always_comb begin
    one_en     = mem_read_en ^ mem_write_en;
    any_en     = mem_read_en | mem_write_en;
    req_ok     = (state_q == IDLE) && one_en && access_legal(length, addr[1:0]);
    req_bad    = (state_q == IDLE) && any_en && !req_ok;
    stall      = req_ok || (state_q == REQ);
    access_err = req_bad || tmo_err_q;
    read_data  = req_bad ? '0 : read_data_q;
  end

  // Next-state and registered-output computation for the bus FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    len_d       = len_q;
    sign_d      = sign_q;
    off_d       = off_q;
    read_data_d = read_data_q;
    tmo_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_ok) begin
          state_d     = REQ;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write_en;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_be_d    = st_be;
          bus_wdata_d = st_lanes;
          len_d       = length;
          sign_d      = sign;
          off_d       = addr[1:0];
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An ack in the final allowed cycle still wins over the timeout.
        if (bus_ack) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          if (!bus_we_q) read_data_d = ld_data;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          tmo_err_d = 1'b1;
          if (!bus_we_q) read_data_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered bus outputs, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      len_q       <= LEN_BYTE;
      sign_q      <= 1'b0;
      off_q       <= '0;
      read_data_q <= '0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      len_q       <= len_d;
      sign_q      <= sign_d;
      off_q       <= off_d;
      read_data_q <= read_data_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule
